// File: rtl/ts_ctrl_pkg.sv
// Shared definitions for the trigger-scintillator spy capture sequencer:
// state encodings, trigger-mode codes and default sizes.
package ts_ctrl_pkg;

  localparam int unsigned SPY_DEPTH_DEF = 64;
  localparam int unsigned CNT_W_DEF     = 16;
  localparam int unsigned MODE_W        = 2;
  localparam int unsigned DEPTH_W       = 6;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

  localparam logic [MODE_W-1:0] TRIG_IMM = 2'd0;
  localparam logic [MODE_W-1:0] TRIG_EXT = 2'd1;
  localparam logic [MODE_W-1:0] TRIG_PER = 2'd2;

endpackage

// File: rtl/ts_trig_sel.sv
// Wait counter plus trigger / timeout decode for the WAIT_TRIG phase.
// Both indications are combinational and only valid while in_wait_i is high.
module ts_trig_sel
  import ts_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_wait_i,
  input  logic [MODE_W-1:0] trig_mode_i,
  input  logic              ext_trig_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  timeout_i,
  output logic              trig_c_o,
  output logic              expired_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_raw;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Timeout fires on the cycle in which the counter advances onto timeout_i.
  always_comb begin
    trig_raw = 1'b0;
    unique case (trig_mode_i)
      TRIG_EXT: trig_raw = ext_trig_i;
      TRIG_PER: trig_raw = (cnt_q == period_i);
      TRIG_IMM: trig_raw = 1'b1;
      default:  trig_raw = 1'b1;
    endcase
    trig_c_o    = in_wait_i && trig_raw;
    expired_c_o = in_wait_i && !trig_raw && (timeout_i != '0)
                  && (cnt_q == (timeout_i - CNT_W'(1)));
    cnt_d       = in_wait_i ? (cnt_q + CNT_W'(1)) : '0;
  end

endmodule

// File: rtl/ts_spy_sequencer.sv
// Capture scheduler for the two per-link spy buffers: arm, wait for the
// selected trigger, hold a fixed capture window, optionally re-arm.
module ts_spy_sequencer
  import ts_ctrl_pkg::*;
#(
  parameter int unsigned SPY_DEPTH = SPY_DEPTH_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic               axi_clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MODE_W-1:0]  trig_mode,
  input  logic               ext_trig,
  input  logic [CNT_W-1:0]   period,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [CNT_W-1:0]   timeout,
  input  logic               rearm,
  output logic               spy_start,
  output logic               spy_window,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   n_captures
);

  localparam int unsigned CAP_W = $clog2(SPY_DEPTH + 1);

  seq_state_e       state_q, state_d;
  logic [CAP_W-1:0] cap_q, cap_d, cap_last;
  logic [CNT_W-1:0] ncap_q, ncap_d;
  logic             timed_out_q, timed_out_d;
  logic             spy_start_q, spy_start_d;
  logic             spy_window_q, spy_window_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_wait, trig, expired;

  assign in_wait  = (state_q == ST_WAIT_TRIG) && !abort;
  assign cap_last = (depth == '0) ? CAP_W'(SPY_DEPTH - 1) : (CAP_W'(depth) - CAP_W'(1));

  ts_trig_sel #(
    .CNT_W (CNT_W)
  ) u_trig_sel (
    .clk_i       (axi_clk),
    .rst_i       (reset),
    .in_wait_i   (in_wait),
    .trig_mode_i (trig_mode),
    .ext_trig_i  (ext_trig),
    .period_i    (period),
    .timeout_i   (timeout),
    .trig_c_o    (trig),
    .expired_c_o (expired)
  );

  always_ff @(posedge axi_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cap_q        <= '0;
      ncap_q       <= '0;
      timed_out_q  <= 1'b0;
      spy_start_q  <= 1'b0;
      spy_window_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      ncap_q       <= ncap_d;
      timed_out_q  <= timed_out_d;
      spy_start_q  <= spy_start_d;
      spy_window_q <= spy_window_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    cap_d       = '0;
    ncap_d      = ncap_q;
    timed_out_d = timed_out_q;

    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_ARM;
      ST_ARM:  state_d = ST_WAIT_TRIG;
      ST_WAIT_TRIG: begin
        if (trig) begin
          state_d = ST_CAPTURE;
        end else if (expired) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (cap_q == cap_last) begin
          state_d = ST_DONE;
          if (ncap_q != '1) ncap_d = ncap_q + CNT_W'(1);
        end else begin
          cap_d = cap_q + CAP_W'(1);
        end
      end
      ST_DONE: if (start || rearm) state_d = ST_ARM;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ARM) timed_out_d = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      cap_d       = '0;
      ncap_d      = '0;
      timed_out_d = 1'b0;
    end

    spy_start_d  = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);
    spy_window_d = (state_d == ST_CAPTURE);
    busy_d       = (state_d == ST_ARM) || (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
    done_d       = (state_d == ST_DONE);
  end

  assign spy_start  = spy_start_q;
  assign spy_window = spy_window_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign state      = STATE_W'(state_q);
  assign n_captures = ncap_q;

endmodule

// File: tb/tb_ts_spy_sequencer.sv
// Scoreboard bench for ts_spy_sequencer: each scenario queues the expected
// per-cycle output vector, which is compared when that cycle is sampled.
module tb_ts_spy_sequencer;

  logic        axi_clk = 1'b0;
  logic        reset, start, abort, ext_trig, rearm;
  logic [1:0]  trig_mode;
  logic [15:0] period, timeout;
  logic [5:0]  depth;
  logic        spy_start, spy_window, busy, done, timed_out;
  logic [2:0]  state;
  logic [15:0] n_captures;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [31:0] v;
  } sb_t;
  sb_t sb[$];

  ts_spy_sequencer #(.SPY_DEPTH(64), .CNT_W(16)) dut (
    .axi_clk    (axi_clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .ext_trig   (ext_trig),
    .period     (period),
    .depth      (depth),
    .timeout    (timeout),
    .rearm      (rearm),
    .spy_start  (spy_start),
    .spy_window (spy_window),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .state      (state),
    .n_captures (n_captures)
  );

  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] obs();
    return {n_captures, 5'b0, state, 3'b0, spy_start, spy_window, busy, done, timed_out};
  endfunction

  function automatic logic [31:0] mk(input int st, input bit ss, input bit sw, input bit bz,
                                     input bit dn, input bit to, input int n);
    return {16'(n), 5'b0, 3'(st), 3'b0, ss, sw, bz, dn, to};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input string tag, input logic [31:0] v);
    sb_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  // Advance to the next mid-cycle sample point and retire due expectations.
  task automatic cycle();
    sb_t e;
    @(negedge axi_clk);
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(), e.v);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Start sampled in cycle t0: ARM, wait_n WAIT_TRIG cycles, len CAPTURE cycles, DONE.
  task automatic push_run(input string tag, input int t0, input int wait_n, input int len, input int n0);
    int c = t0 + 1;
    push(c, tag, mk(1, 0, 0, 1, 0, 0, n0)); c++;
    repeat (wait_n) begin push(c, tag, mk(2, 0, 0, 1, 0, 0, n0)); c++; end
    for (int i = 0; i < len; i++) begin push(c, tag, mk(3, i == 0, 1, 1, 0, 0, n0)); c++; end
    push(c, tag, mk(4, 0, 0, 0, 1, 0, n0 + 1));
  endtask

  task automatic push_tmo(input string tag, input int t0, input int tmo, input int n0);
    int c = t0 + 1;
    push(c, tag, mk(1, 0, 0, 1, 0, 0, n0)); c++;
    repeat (tmo) begin push(c, tag, mk(2, 0, 0, 1, 0, 0, n0)); c++; end
    push(c, tag, mk(4, 0, 0, 0, 1, 1, n0));
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ext_trig = 1'b0; rearm = 1'b0;
    trig_mode = 2'd0; period = 16'd0; timeout = 16'd0; depth = 6'd8;

    cycle();
    push(cyc + 1, "reset", mk(0, 0, 0, 0, 0, 0, 0));
    push(cyc + 2, "reset", mk(0, 0, 0, 0, 0, 0, 0));
    cycle(); cycle();
    reset = 1'b0;
    push(cyc + 1, "idle", mk(0, 0, 0, 0, 0, 0, 0));
    drain();

    // Mode 0, depth 8; DONE holds without rearm.
    t = cyc; start = 1'b1;
    push_run("m0_d8", t, 1, 8, 0);
    push(t + 12, "m0_d8_hold", mk(4, 0, 0, 0, 1, 0, 1));
    cycle(); start = 1'b0;
    drain();

    // Mode 2, period 5, depth 0 -> full 64-cycle window.
    trig_mode = 2'd2; period = 16'd5; depth = 6'd0;
    t = cyc; start = 1'b1;
    push_run("m2_p5", t, 6, 64, 1);
    cycle(); start = 1'b0;
    drain();

    // Mode 1 timeout; ext_trig seen only outside WAIT_TRIG must be ignored.
    trig_mode = 2'd1; timeout = 16'd10; depth = 6'd8;
    t = cyc; start = 1'b1; ext_trig = 1'b1;
    push_tmo("m1_tmo", t, 10, 2);
    cycle(); start = 1'b0;
    cycle(); ext_trig = 1'b0;
    drain();

    // Mode 1, ext_trig on the same cycle as timeout expiry: trigger wins.
    depth = 6'd2;
    t = cyc; start = 1'b1;
    push_run("m1_race", t, 10, 2, 2);
    cycle(); start = 1'b0;
    while (cyc < t + 11) cycle();
    ext_trig = 1'b1;
    cycle(); ext_trig = 1'b0;
    drain();

    // Rearm: three back-to-back runs, start while busy ignored.
    trig_mode = 2'd0; timeout = 16'd0; depth = 6'd4; rearm = 1'b1;
    t = cyc; start = 1'b1;
    push_run("rearm1", t, 1, 4, 3);
    push_run("rearm2", t + 7, 1, 4, 4);
    push_run("rearm3", t + 14, 1, 4, 5);
    push(t + 22, "rearm_stop", mk(4, 0, 0, 0, 1, 0, 6));
    cycle(); start = 1'b0;
    while (cyc < t + 4) cycle();
    start = 1'b1;
    cycle(); start = 1'b0;
    while (cyc < t + 21) cycle();
    rearm = 1'b0;
    drain();

    // Asynchronous reset while waiting on an external trigger.
    trig_mode = 2'd1;
    t = cyc; start = 1'b1;
    push(t + 1, "rst_wait", mk(1, 0, 0, 1, 0, 0, 6));
    push(t + 2, "rst_wait", mk(2, 0, 0, 1, 0, 0, 6));
    push(t + 3, "rst_wait", mk(2, 0, 0, 1, 0, 0, 6));
    cycle(); start = 1'b0;
    while (cyc < t + 3) cycle();
    #2 reset = 1'b1;
    #1 check_eq("async_reset", obs(), mk(0, 0, 0, 0, 0, 0, 0));
    cycle(); reset = 1'b0;
    push(cyc + 1, "post_reset", mk(0, 0, 0, 0, 0, 0, 0));
    drain();

    // Abort in the middle of CAPTURE.
    trig_mode = 2'd0; depth = 6'd8;
    t = cyc; start = 1'b1;
    push_run("pre_abort", t, 1, 8, 0);
    cycle(); start = 1'b0;
    drain();
    t = cyc; start = 1'b1;
    push(t + 1, "abort_cap", mk(1, 0, 0, 1, 0, 0, 1));
    push(t + 2, "abort_cap", mk(2, 0, 0, 1, 0, 0, 1));
    push(t + 3, "abort_cap", mk(3, 1, 1, 1, 0, 0, 1));
    push(t + 4, "abort_cap", mk(3, 0, 1, 1, 0, 0, 1));
    push(t + 5, "abort_cap", mk(3, 0, 1, 1, 0, 0, 1));
    push(t + 6, "abort_cap", mk(0, 0, 0, 0, 0, 0, 0));
    push(t + 7, "abort_cap", mk(0, 0, 0, 0, 0, 0, 0));
    cycle(); start = 1'b0;
    while (cyc < t + 5) cycle();
    abort = 1'b1;
    cycle(); abort = 1'b0;
    drain();

    // Start and abort together from DONE: abort wins.
    depth = 6'd2;
    t = cyc; start = 1'b1;
    push_run("pre_sa", t, 1, 2, 0);
    cycle(); start = 1'b0;
    drain();
    t = cyc; start = 1'b1; abort = 1'b1;
    push(t + 1, "start_abort", mk(0, 0, 0, 0, 0, 0, 0));
    push(t + 2, "start_abort", mk(0, 0, 0, 0, 0, 0, 0));
    cycle(); start = 1'b0; abort = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
